// File: rtl/fifo_sc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_pkg
// Description : Shared constants and helpers for the single-clock FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sc_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int FWFT_STANDARD   = 0;
  localparam int FWFT_SHOW_AHEAD = 1;

  // Ceiling log2, used when sizing address fields from a word count
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sc_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_if
// Description : Producer/consumer bundle for fifo_sc (write, read, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sc_if
  import fifo_sc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 2
);
  logic         we;
  logic [W-1:0] wd;
  logic         re;
  logic [W-1:0] rd;
  logic         rvalid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [N:0]   usedw;
  logic         ovf;
  logic         udf;

  // Side that drives requests (producer/consumer)
  modport master (
    output we, wd, re,
    input  rd, rvalid, full, empty, almost_full, almost_empty, usedw, ovf, udf
  );

  // FIFO side
  modport slave (
    input  we, wd, re,
    output rd, rvalid, full, empty, almost_full, almost_empty, usedw, ovf, udf
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sc_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc_ram_sdp
// Description : Simple dual-port RAM, W x 2**N, one write port and one
//               registered read port. Read-during-write to the same address
//               returns the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sc_ram_sdp
  import fifo_sc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [N-1:0] raddr,
  output logic [W-1:0] rdata
);
  localparam int DEPTH = 1 << N;

  logic [W-1:0] mem [0:DEPTH-1];
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  // Storage array: no reset, contents are only meaningful via FIFO pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port holds its last word unless a read is enabled
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Registered read data, cleared on reset so rd starts at zero
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/fifo_sc.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sc
// Description : Single-clock FIFO with optional show-ahead read, threshold
//               flags, fill level and sticky overflow/underflow errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sc
  import fifo_sc_pkg::*;
#(
  parameter int W     = 4,
  parameter int N     = 2,
  parameter int FWFT  = 0,
  parameter int AF_TH = 3,
  parameter int AE_TH = 1
) (
  input  logic     clk,
  input  logic     rst,
  fifo_sc_if.slave bus
);
  localparam logic [N:0] ONE    = (N+1)'(1);
  localparam logic [N:0] AF_LVL = (N+1)'(AF_TH);
  localparam logic [N:0] AE_LVL = (N+1)'(AE_TH);

  logic [N:0]   wptr_q, wptr_d, rptr_q, rptr_d, usedw_q, usedw_d;
  logic         full_q, full_d, empty_q, empty_d;
  logic         af_q, af_d, ae_q, ae_d;
  logic         ovf_q, ovf_d, udf_q, udf_d;
  logic         wr_acc, rd_acc;

  logic         ram_re;
  logic [N-1:0] ram_raddr;
  logic [W-1:0] ram_rdata;

  // Accept logic, pointer/level update and next-state flags
  always_comb begin
    rd_acc  = bus.re && !empty_q;
    // A full FIFO can still take a write when a read frees a slot this cycle
    wr_acc  = bus.we && (!full_q || rd_acc);
    wptr_d  = wr_acc ? wptr_q + ONE : wptr_q;
    rptr_d  = rd_acc ? rptr_q + ONE : rptr_q;
    usedw_d = usedw_q;
    if (wr_acc && !rd_acc)      usedw_d = usedw_q + ONE;
    else if (!wr_acc && rd_acc) usedw_d = usedw_q - ONE;
    // Same index with differing wrap bit means one full lap apart
    full_d  = (wptr_d[N] != rptr_d[N]) && (wptr_d[N-1:0] == rptr_d[N-1:0]);
    empty_d = (wptr_d == rptr_d);
    af_d    = (usedw_d >= AF_LVL);
    ae_d    = (usedw_d <= AE_LVL);
    ovf_d   = ovf_q | (bus.we & ~wr_acc);
    udf_d   = udf_q | (bus.re & empty_q);
  end

  // Pointer, level and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usedw_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usedw_q <= usedw_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_sc_ram_sdp #(
    .W (W),
    .N (N)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wptr_q[N-1:0]),
    .wdata (bus.wd),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  if (FWFT == FWFT_SHOW_AHEAD) begin : g_fwft
    // The RAM continuously prefetches the next head. When the word being
    // written lands exactly on the next head slot (usedw becomes 1 with
    // this word), the RAM returns the stale entry, so a bypass register
    // supplies the fresh word instead.
    logic         byp_q, byp_d;
    logic [W-1:0] byp_data_q, byp_data_d;

    // Detect a write that becomes the head on the next cycle
    always_comb begin
      byp_d      = wr_acc && (wptr_q[N-1:0] == rptr_d[N-1:0]);
      byp_data_d = bus.wd;
    end

    // Bypass registers
    always_ff @(posedge clk) begin
      if (rst) begin
        byp_q      <= 1'b0;
        byp_data_q <= '0;
      end else begin
        byp_q      <= byp_d;
        byp_data_q <= byp_data_d;
      end
    end

    assign ram_re     = 1'b1;
    assign ram_raddr  = rptr_d[N-1:0];
    assign bus.rd     = byp_q ? byp_data_q : ram_rdata;
    assign bus.rvalid = !empty_q;
  end else begin : g_std
    logic rvalid_q, rvalid_d;

    // Data is valid for exactly the cycle after an accepted read
    always_comb begin
      rvalid_d = rd_acc;
    end

    // Read-valid register
    always_ff @(posedge clk) begin
      if (rst) rvalid_q <= 1'b0;
      else     rvalid_q <= rvalid_d;
    end

    assign ram_re     = rd_acc;
    assign ram_raddr  = rptr_q[N-1:0];
    assign bus.rd     = ram_rdata;
    assign bus.rvalid = rvalid_q;
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.usedw        = usedw_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
endmodule
`default_nettype wire
